// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional LOADER_CHECKSUM_EN adds a running word checksum output.
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD      = 4;
    localparam int DEFAULT_DEPTH_BYTES = 48;
    localparam int BYTE_IDX_W          = 2;

    // Big-endian lane select: index 0 is the most significant byte.
    function automatic logic [7:0] be_byte(
        input logic [31:0]           w,
        input logic [BYTE_IDX_W-1:0] idx
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (idx)
            2'd0: b = w[31:24];
            2'd1: b = w[23:16];
            2'd2: b = w[15:8];
            2'd3: b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instr_mem_loader_serializer.sv
// Word-to-byte serializer: holds the accepted word and walks its bytes
// most significant first, one per cycle while stepping.
module word_byte_serializer
    import instr_mem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [31:0]           word_i,
    output logic [BYTE_IDX_W-1:0] idx_o,
    output logic [7:0]            byte_o,
    output logic                  last_byte_o
);

    logic [31:0]           word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = '0;
        end else if (step_i) begin
            idx_d = idx_q + BYTE_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign byte_o      = be_byte(word_q, idx_q);
    assign last_byte_o = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams 32-bit words into a byte-wide instruction memory, big-endian.
// Define LOADER_CHECKSUM_EN to add a modulo-2^32 checksum of loaded words.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic [ADDR_W-1:0] word_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                last_q, last_d;

    logic                in_idle_done;
    logic                in_accept;
    logic                in_write;
    logic                start;
    logic                xfer;
    logic [BYTE_IDX_W-1:0] idx;
    logic [7:0]          ser_byte;
    logic                last_byte;
    logic [ADDR_W-1:0]   byte_addr;
    logic                at_cap;

    assign in_idle_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign in_accept    = (state_q == ST_ACCEPT);
    assign in_write     = (state_q == ST_WRITE);
    assign start        = in_idle_done && load_start;
    assign xfer         = in_accept && word_valid;

    word_byte_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (xfer),
        .step_i      (in_write),
        .word_i      (word_data),
        .idx_o       (idx),
        .byte_o      (ser_byte),
        .last_byte_o (last_byte)
    );

    assign byte_addr = addr_q + ADDR_W'(idx);
    // The final byte of memory ends the session even without word_last.
    assign at_cap    = (byte_addr == ADDR_W'(DEPTH_BYTES - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d = ST_ACCEPT;
                    addr_d  = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (word_valid) begin
                    last_d  = word_last;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_byte) begin
                    count_d = count_q + ADDR_W'(1);
                    addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
                    state_d = (last_q || at_cap) ? ST_DONE : ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + word_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

    assign word_ready = in_accept;
    assign mem_we     = in_write;
    assign mem_addr   = in_write ? byte_addr : '0;
    assign mem_wdata  = in_write ? ser_byte : 8'h00;
    assign busy       = in_accept || in_write;
    assign done       = (state_q == ST_DONE);
    assign word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader against a byte-stream model.
// Build with LOADER_CHECKSUM_EN to also check the checksum output.
module tb_instr_mem_loader;

    localparam int DEPTH = 48;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          word_valid;
    logic [31:0]   word_data;
    logic          word_last;
    logic          word_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          obs_addr[$];
    int          obs_data[$];
    int          obs_cyc[$];
    int          xfer_cyc[$];
    logic [31:0] sent[$];
    int          exp_addr[$];
    int          exp_data[$];
    int          bad_idle  = 0;
    int          bad_range = 0;

    instr_mem_loader #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
`ifdef LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                obs_addr.push_back(int'(mem_addr));
                obs_data.push_back(int'(mem_wdata));
                obs_cyc.push_back(cyc);
                if (mem_addr >= AW'(DEPTH)) bad_range++;
            end else if (mem_addr != '0 || mem_wdata != 8'h00) begin
                bad_idle++;
            end
            if (word_valid && word_ready) xfer_cyc.push_back(cyc);
        end
    end

    // Expected byte stream: word i lands at 4i..4i+3, MSB first.
    function automatic void build_expect();
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < sent.size(); i++) begin
            for (int b = 0; b < 4; b++) begin
                exp_addr.push_back(4 * i + b);
                exp_data.push_back(int'((sent[i] >> (24 - 8 * b)) & 32'hFF));
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        xfer_cyc.delete();
        sent.delete();
    endtask

    task automatic start_session();
        clear_logs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = l;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (word_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word_ready=0 after 20 cycles, required 1");
        end else begin
            sent.push_back(d);
        end
        tick();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL done_timeout: done=0 after 100 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_start = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        #1;
        n_cmp++;
        if ({word_ready, mem_we, busy, done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 0000",
                     {word_ready, mem_we, busy, done});
        end
        n_cmp++;
        if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_bus: addr=%h data=%h required 0",
                     mem_addr, mem_wdata);
        end
        n_cmp++;
        if (word_count !== '0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d required 0", word_count);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (word_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: ready=%b busy=%b required 0 0",
                     word_ready, busy);
        end
    endtask

    task automatic test_single_word();
        start_session();
        send_word(32'h8C10_0000, 1'b1);
        wait_done();
        build_expect();
        n_cmp++;
        if (obs_addr.size() != 4) begin
            n_bad++;
            $display("FAIL single_nbytes: got %0d required 4", obs_addr.size());
        end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]
                || obs_cyc[i] != xfer_cyc[0] + 1 + i) begin
                n_bad++;
                $display("FAIL single_byte%0d: got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d",
                         i, obs_addr[i], obs_data[i], obs_cyc[i],
                         exp_addr[i], exp_data[i], xfer_cyc[0] + 1 + i);
            end
        end
        n_cmp++;
        if (word_count !== AW'(1) || busy !== 1'b0 || word_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: count=%0d busy=%b ready=%b required 1 0 0",
                     word_count, busy, word_ready);
        end
    endtask

    task automatic test_random_sessions();
        int          lastpos;
        int          n_exp;
        logic [31:0] w;
        logic [31:0] sum;
        for (int s = 0; s < 4; s++) begin
            lastpos = $urandom_range(0, 15);
            n_exp   = (lastpos < 11 ? lastpos : 11) + 1;
            sum     = '0;
            start_session();
            for (int i = 0; i < n_exp; i++) begin
                w = $urandom;
                sum = sum + w;
                repeat ($urandom_range(0, 3)) tick();
                send_word(w, i == lastpos);
            end
            wait_done();
            build_expect();
            n_cmp++;
            if (obs_addr.size() != exp_addr.size()) begin
                n_bad++;
                $display("FAIL rand%0d_nbytes: got %0d required %0d",
                         s, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
                n_cmp++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]
                    || obs_cyc[i] != xfer_cyc[i / 4] + 1 + (i % 4)) begin
                    n_bad++;
                    $display("FAIL rand%0d_byte%0d: got a=%0d d=%h required a=%0d d=%h",
                             s, i, obs_addr[i], obs_data[i],
                             exp_addr[i], exp_data[i]);
                end
            end
            n_cmp++;
            if (word_count !== AW'(n_exp)) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d required %0d",
                         s, word_count, n_exp);
            end
`ifdef LOADER_CHECKSUM_EN
            n_cmp++;
            if (checksum !== sum) begin
                n_bad++;
                $display("FAIL rand%0d_checksum: got %h required %h",
                         s, checksum, sum);
            end
`endif
        end
    endtask

    task automatic test_full_fill();
        int rdy_seen;
        int nb;
        start_session();
        for (int i = 0; i < DEPTH / 4; i++) send_word($urandom, 1'b0);
        wait_done();
        build_expect();
        n_cmp++;
        if (obs_addr.size() != DEPTH || obs_addr[obs_addr.size() - 1] != DEPTH - 1) begin
            n_bad++;
            $display("FAIL fill_span: got %0d bytes required %0d ending at %0d",
                     obs_addr.size(), DEPTH, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_bad++;
                $display("FAIL fill_byte%0d: got a=%0d d=%h required a=%0d d=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (word_count !== AW'(DEPTH / 4)) begin
            n_bad++;
            $display("FAIL fill_count: got %0d required %0d", word_count, DEPTH / 4);
        end
        nb = obs_addr.size();
        rdy_seen = 0;
        tick();
        word_valid = 1'b1;
        word_data  = 32'hDEAD_BEEF;
        repeat (6) begin
            @(negedge clk);
            if (word_ready) rdy_seen++;
        end
        tick();
        word_valid = 1'b0;
        n_cmp++;
        if (rdy_seen != 0 || obs_addr.size() != nb || done !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_13th: ready_cycles=%0d new_bytes=%0d done=%b required 0 0 1",
                     rdy_seen, obs_addr.size() - nb, done);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        start_session();
        word_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word_data = $urandom;
            word_last = (i == 3);
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (word_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bp_timeout%0d: word_ready=0 after 20 cycles, required 1", i);
            end else begin
                sent.push_back(word_data);
            end
            tick();
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        wait_done();
        n_cmp++;
        if (xfer_cyc.size() != 4) begin
            n_bad++;
            $display("FAIL bp_nxfer: got %0d required 4", xfer_cyc.size());
        end
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            n_cmp++;
            if (xfer_cyc[i] - xfer_cyc[i - 1] != 5) begin
                n_bad++;
                $display("FAIL bp_gap%0d: got %0d required 5",
                         i, xfer_cyc[i] - xfer_cyc[i - 1]);
            end
        end
        build_expect();
        n_cmp++;
        if (obs_addr.size() != 16 || obs_data[15] != exp_data[15]) begin
            n_bad++;
            $display("FAIL bp_bytes: got %0d bytes required 16 with last matching",
                     obs_addr.size());
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        start_session();
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b0);
        word_valid = 1'b1;
        word_data  = $urandom;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_we && mem_addr == AW'(9)) begin
                ok = 1'b1;
                break;
            end
        end
        word_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rmid_reach: addr 9 never written, required a write");
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_we: got %b required 0", mem_we);
        end
        n_cmp++;
        if ({word_ready, busy, done} !== 3'b000 || mem_addr !== '0
            || mem_wdata !== 8'h00 || word_count !== '0) begin
            n_bad++;
            $display("FAIL rmid_outs: rdy/busy/done=%b a=%h d=%h cnt=%0d required all 0",
                     {word_ready, busy, done}, mem_addr, mem_wdata, word_count);
        end
        n_cmp++;
        if (obs_addr.size() != 10) begin
            n_bad++;
            $display("FAIL rmid_prior: got %0d bytes required 10", obs_addr.size());
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (obs_addr.size() != 10 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_quiet: bytes=%0d busy=%b required 10 0",
                     obs_addr.size(), busy);
        end
        start_session();
        send_word(32'h1234_5678, 1'b1);
        wait_done();
        n_cmp++;
        if (obs_addr.size() != 4 || obs_addr[0] != 0 || obs_data[0] != 8'h12
            || word_count !== AW'(1)) begin
            n_bad++;
            $display("FAIL rmid_restart: bytes=%0d cnt=%0d required 4 from addr 0 cnt 1",
                     obs_addr.size(), word_count);
        end
    endtask

    task automatic test_ignored_start();
        start_session();
        send_word($urandom, 1'b0);
        load_start = 1'b1;
        tick();
        tick();
        load_start = 1'b0;
        send_word($urandom, 1'b1);
        wait_done();
        build_expect();
        n_cmp++;
        if (word_count !== AW'(2) || obs_addr.size() != 8) begin
            n_bad++;
            $display("FAIL ign_count: cnt=%0d bytes=%0d required 2 8",
                     word_count, obs_addr.size());
        end
        for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
                n_bad++;
                $display("FAIL ign_byte%0d: got a=%0d d=%h required a=%0d d=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (xfer_cyc.size() != 2 || xfer_cyc[1] - xfer_cyc[0] != 5) begin
            n_bad++;
            $display("FAIL ign_gap: nxfer=%0d required 2 transfers 5 cycles apart",
                     xfer_cyc.size());
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        start_session();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b1);
        wait_done();
        n_cmp++;
        if (checksum !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL checksum_wrap: got %h required 00000000", checksum);
        end
    endtask
`endif

    task automatic test_bus_hygiene();
        n_cmp++;
        if (bad_range != 0 || bad_idle != 0) begin
            n_bad++;
            $display("FAIL bus_hygiene: out_of_range=%0d nonzero_idle=%0d required 0 0",
                     bad_range, bad_idle);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_random_sessions();
        test_full_fill();
        test_backpressure();
        test_reset_mid_word();
        test_ignored_start();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_bus_hygiene();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
